alu_step_ctrl: RTL and testbench
================================

Name: alu_step_ctrl

Overview:
Multicycle control FSM that sequences the shared ALU for one instruction per start request. For each cycle it drives the ALU operand selects (ALUSrcA, ALUSrcB), the operation class (ALUOp), and the register, PC and memory write strobes. It sits between the instruction register/opcode decode and the datapath operand muxes. The ALUSrcB encodings it drives are the datapath's fixed encodings:
- 0 = B register
- 1 = constant 4
- 2 = sign-extended immediate
- 3 = MDR
- 4 = shifted immediate

Parameters:
MEM_TIMEOUT, 16, max cycles spent waiting for mem_ready in a memory state before aborting to ERR (range 1..31)
CNT_W, 5, width of the memory wait counter

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request to run one instruction; sampled only in IDLE
opcode  input  6  instruction opcode from IR (valid from DECODE onward)
zero  input  1  ALU zero flag, used in BRANCH
mem_ready  input  1  memory completion for the current read/write
ALUSrcA  output  2  0=PC, 1=A register
ALUSrcB  output  3  operand B select, encodings above
ALUOp  output  3  0=ADD, 1=SUB, 2=use funct field
PCWrite  output  1  PC load strobe
PCSrc  output  1  0=ALU result, 1=ALUOut (branch target)
IRWrite  output  1  IR load strobe
RegWrite  output  1  register file write strobe
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
error  output  1  one-cycle pulse with done on an illegal opcode or timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_LD, BRANCH, DONE, ERR.
- Outputs are a decode of the state register (Moore), except PCWrite in BRANCH. Any output not listed for a state is 0.
- Reset (async, reset=0): state goes to IDLE, the wait counter clears, and all outputs are 0 immediately. This holds mid-instruction too: no strobe survives into the cycle after reset is asserted.
- IDLE: if start=1, go to FETCH. start is ignored in every other state.
- FETCH: ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCWrite=1, IRWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=4, ALUOp=0 (branch target precomputed into ALUOut). Next state by opcode:
  - 0x00 → EXEC_R
  - 0x08 → EXEC_I
  - 0x23 or 0x2B → ADDR
  - 0x04 or 0x05 → BRANCH
  - any other opcode → ERR
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Next state is WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next state is WB_I.
- ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next state is MEM_RD for 0x23, MEM_WR for 0x2B. The wait counter clears on entry.
- MEM_RD / MEM_WR:
  - MemRead=1 (MEM_RD) or MemWrite=1 (MEM_WR), held each cycle until exit.
  - mem_ready=1 → WB_LD (from MEM_RD) or DONE (from MEM_WR).
  - Otherwise the counter increments. The transition to ERR is taken in the cycle where the counter equals MEM_TIMEOUT-1 and mem_ready=0.
  - mem_ready in that same cycle wins over timeout.
- WB_R / WB_I / WB_LD: RegWrite=1. Next state is DONE.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSrc=1.
  - PCWrite = zero for opcode 0x04, ~zero for 0x05 (combinational in this state only).
  - Next state is DONE.
- DONE: done=1, busy=1. Next state is IDLE; a start held high starts the next instruction one cycle later.
- ERR: done=1, error=1, no write strobes. Next state is IDLE.
- ALUSrcB=3 (MDR) is never driven by this block; it is reserved for the extended load path.
- Latency from start sampled in IDLE to the done cycle:
  - R-type / addi: 5 cycles
  - beq / bne: 4 cycles
  - sw: 4+w cycles
  - lw: 5+w cycles
  - w = number of MEM cycles, minimum 1

Test Plan:
- R-type (opcode 0x00), start pulse at cycle 0 → states in cycles 1–5 are FETCH, DECODE, EXEC_R, WB_R, DONE.
  - ALUSrcB sequence: 1, 4, 0.
  - RegWrite=1 only in cycle 4; done=1 only in cycle 5; busy low again in cycle 6.
- lw (0x23) with mem_ready asserted on the 3rd MEM_RD cycle → MemRead high for exactly 3 cycles, then WB_LD with RegWrite=1, done at cycle 8, error=0.
- beq (0x04): zero=1 → PCWrite=1 and PCSrc=1 in the BRANCH cycle. Repeat with zero=0 → PCWrite=0. bne (0x05) gives inverted results. done at cycle 4.
- Illegal opcode 0x3F → DECODE then ERR; done=1 and error=1 in the same cycle (cycle 3); no RegWrite, MemWrite or branch PCWrite at any point.
- sw (0x2B) with mem_ready held 0 and MEM_TIMEOUT=16 → MemWrite high for exactly 16 cycles, then ERR pulse, then IDLE.
  - Variant: mem_ready=1 in the 16th cycle → DONE instead of ERR.
- Reset asserted (reset=0) asynchronously mid-MEM_RD → all outputs 0 before the next clock edge; after release, state is IDLE and start is required to begin again.

Source files
------------

// File: rtl/alu_step_ctrl.sv
// Multicycle ALU step controller: sequences operand selects, ALU op class and
// write strobes for one instruction per start request.
module alu_step_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StAddr,
        StMemRd,
        StMemWr,
        StWbR,
        StWbI,
        StWbLd,
        StBranch,
        StDone,
        StErr
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and memory wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and wait counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpRtype:     state_d = StExecR;
                    OpAddi:      state_d = StExecI;
                    OpLw, OpSw:  state_d = StAddr;
                    OpBeq, OpBne: state_d = StBranch;
                    default:     state_d = StErr;
                endcase
            end
            StExecR:  state_d = StWbR;
            StExecI:  state_d = StWbI;
            StAddr: begin
                cnt_d   = '0;
                state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd, StMemWr: begin
                // A completion in the final allowed cycle beats the timeout.
                if (mem_ready) begin
                    state_d = (state_q == StMemRd) ? StWbLd : StDone;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWbR, StWbI, StWbLd: state_d = StDone;
            StBranch: state_d = StDone;
            StDone:   state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Moore output decode; only the branch PCWrite looks at an input.
    always_comb begin
        ALUSrcA  = 2'd0;
        ALUSrcB  = 3'd0;
        ALUOp    = 3'd0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        busy     = (state_q != StIdle);
        unique case (state_q)
            StFetch: begin
                ALUSrcB = 3'd1;
                PCWrite = 1'b1;
                IRWrite = 1'b1;
            end
            StDecode: ALUSrcB = 3'd4;
            StExecR: begin
                ALUSrcA = 2'd1;
                ALUOp   = 3'd2;
            end
            StExecI, StAddr: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 3'd2;
            end
            StMemRd: MemRead  = 1'b1;
            StMemWr: MemWrite = 1'b1;
            StWbR, StWbI, StWbLd: RegWrite = 1'b1;
            StBranch: begin
                ALUSrcA = 2'd1;
                ALUOp   = 3'd1;
                PCSrc   = 1'b1;
                PCWrite = (opcode == OpBne) ? ~zero : zero;
            end
            StDone: done = 1'b1;
            StErr: begin
                done  = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Self-checking bench for alu_step_ctrl: per-cycle output traces from a
// trace-building reference model, directed corner cases plus random runs.
module tb_alu_step_ctrl;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       PCWrite, PCSrc, IRWrite, RegWrite, MemRead, MemWrite;
    logic       busy, done, error;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] exp_q[$];
    logic        rdy[32];
    logic        zz[32];

    alu_step_ctrl #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    logic [16:0] outv;
    assign outv = {ALUSrcA, ALUSrcB, ALUOp, PCWrite, PCSrc, IRWrite, RegWrite,
                   MemRead, MemWrite, busy, done, error};

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // One busy cycle's outputs; busy is always 1 here.
    function automatic logic [16:0] ov(input int a, input int b, input int op, input int pcw,
                                        input int pcs, input int irw, input int rw,
                                        input int mr, input int mw, input int dn, input int er);
        return {2'(a), 3'(b), 3'(op), 1'(pcw), 1'(pcs), 1'(irw), 1'(rw), 1'(mr), 1'(mw),
                1'b1, 1'(dn), 1'(er)};
    endfunction

    // Expected trace, one entry per cycle starting at the cycle after start.
    // Entry i sees mem_ready=rdy[i] and zero=zz[i]; the trace ends with one IDLE cycle.
    function automatic void build(input logic [5:0] op);
        logic [16:0] dn_v, er_v;
        dn_v = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        er_v = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        exp_q.delete();
        exp_q.push_back(ov(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(ov(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            6'h00: begin
                exp_q.push_back(ov(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                exp_q.push_back(dn_v);
            end
            6'h08: begin
                exp_q.push_back(ov(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                exp_q.push_back(dn_v);
            end
            6'h04, 6'h05: begin
                exp_q.push_back(ov(1, 0, 1, (op == 6'h04) ? int'(zz[2]) : int'(!zz[2]),
                                   1, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(dn_v);
            end
            6'h23, 6'h2B: begin
                exp_q.push_back(ov(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                for (int k = 0; k < int'(T); k++) begin
                    exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0, int'(op == 6'h23),
                                       int'(op == 6'h2B), 0, 0));
                    if (rdy[3 + k]) begin
                        if (op == 6'h23) exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                        exp_q.push_back(dn_v);
                        break;
                    end
                    if (k == int'(T) - 1) exp_q.push_back(er_v);
                end
            end
            default: exp_q.push_back(er_v);
        endcase
        exp_q.push_back('0);
    endfunction

    function automatic void clear_stim();
        for (int i = 0; i < 32; i++) begin
            rdy[i] = 1'b0;
            zz[i]  = 1'b0;
        end
    endfunction

    // Entered #1 after a rising edge with the DUT idle; leaves it the same way.
    task automatic run_instr(input logic [5:0] op);
        build(op);
        opcode = op;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = rdy[i];
            zero      = zz[i];
            @(negedge clk);
            check($sformatf("op%02h_c%0d", op, i + 1), outv, exp_q[i]);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        logic [5:0] legal[6];
        logic [5:0] op;
        legal[0] = 6'h00; legal[1] = 6'h08; legal[2] = 6'h23;
        legal[3] = 6'h2B; legal[4] = 6'h04; legal[5] = 6'h05;

        clear_stim();
        @(posedge clk); @(posedge clk); #1;
        check("reset_outputs", outv, '0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", outv, '0);

        // Directed cases.
        clear_stim(); run_instr(6'h00);
        clear_stim(); run_instr(6'h08);
        clear_stim(); rdy[5] = 1'b1; run_instr(6'h23);
        clear_stim(); zz[2] = 1'b1; run_instr(6'h04);
        clear_stim(); run_instr(6'h04);
        clear_stim(); zz[2] = 1'b1; run_instr(6'h05);
        clear_stim(); run_instr(6'h05);
        clear_stim(); run_instr(6'h3F);
        clear_stim(); run_instr(6'h2B);
        clear_stim(); rdy[3 + T - 1] = 1'b1; run_instr(6'h2B);
        clear_stim(); run_instr(6'h23);
        clear_stim(); rdy[3] = 1'b1; run_instr(6'h2B);

        // Async reset in the middle of MEM_RD.
        clear_stim();
        opcode = 6'h23;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_memrd", outv, ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        #2 reset = 1'b0;
        #1 check("rst_async_outputs", outv, '0);
        @(posedge clk); #1;
        check("rst_held", outv, '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_release_idle", outv, '0);
        @(posedge clk); #1;
        check("idle_no_start", outv, '0);
        clear_stim(); run_instr(6'h00);

        // Random instructions with random per-cycle mem_ready and zero.
        for (int n = 0; n < 60; n++) begin
            int pick;
            bool_loop: begin end
            pick = $urandom_range(0, 7);
            op = (pick >= 6) ? 6'($urandom_range(0, 63)) : legal[pick];
            for (int i = 0; i < 32; i++) begin
                zz[i]  = 1'($urandom_range(0, 1));
                rdy[i] = (n % 5 == 4) ? 1'b0 : ($urandom_range(0, 3) == 0);
            end
            run_instr(op);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
